// File: rtl/ex_mem_wb_pipe.sv
// ex_mem_wb_pipe: EX/MEM register, doubleword data memory, MEM/WB register.
// Back end of the 64-bit in-order pipeline: branch redirect and writeback.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   stall, flush       hold both stages / kill the incoming instruction
//   ex_valid .. RegWrite   execute-stage outputs and control
//   PCSrc, BranchTarget    registered redirect to fetch
//   mem_err            bad ld/sd address in MEM this cycle
//   wb_valid, wb_RegWrite, wb_rd, wb_data   register-file writeback
module ex_mem_wb_pipe #(
    parameter int DEPTH = 256,
    parameter int IDX_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        ex_valid,
    input  logic [63:0] ALUResult,
    input  logic [63:0] readData2,
    input  logic [63:0] PCPlusImmShifted,
    input  logic        BranchTaken,
    input  logic [4:0]  rd,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        MemtoReg,
    input  logic        RegWrite,
    output logic        PCSrc,
    output logic [63:0] BranchTarget,
    output logic        mem_err,
    output logic        wb_valid,
    output logic        wb_RegWrite,
    output logic [4:0]  wb_rd,
    output logic [63:0] wb_data
);

    logic        r_em_valid;
    logic [63:0] r_em_alu;
    logic [63:0] r_em_sdata;
    logic [63:0] r_em_tgt;
    logic        r_em_taken;
    logic [4:0]  r_em_rd;
    logic        r_em_mr;
    logic        r_em_mw;
    logic        r_em_m2r;
    logic        r_em_rw;

    logic        r_wb_valid;
    logic        r_wb_rw;
    logic [4:0]  r_wb_rd;
    logic [63:0] r_wb_data;

    logic [63:0] r_mem [DEPTH];

    logic [IDX_W-1:0] w_idx;
    logic             w_mis;
    logic             w_oob;
    logic             w_bad;
    logic             w_we;
    logic [63:0]      w_ld_data;

    assign w_idx = r_em_alu[IDX_W+2:3];
    assign w_mis = |r_em_alu[2:0];
    assign w_oob = |r_em_alu[63:IDX_W+3];
    assign w_bad = w_mis | w_oob;

    // Gating on stall keeps a held store to a single write on release.
    assign w_we = r_em_valid & r_em_mw & ~w_bad & ~stall & ~reset;

    // Bad addresses read as zero so a faulting load writes back 0.
    assign w_ld_data = w_bad ? 64'd0 : r_mem[w_idx];

    assign PCSrc        = r_em_valid & r_em_taken;
    assign BranchTarget = r_em_valid ? r_em_tgt : 64'd0;
    assign mem_err      = r_em_valid & (r_em_mr | r_em_mw) & w_bad;

    assign wb_valid    = r_wb_valid;
    assign wb_RegWrite = r_wb_rw;
    assign wb_rd       = r_wb_rd;
    assign wb_data     = r_wb_data;

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_idx] <= r_em_sdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_em_valid <= 1'b0;
            r_em_alu   <= 64'd0;
            r_em_sdata <= 64'd0;
            r_em_tgt   <= 64'd0;
            r_em_taken <= 1'b0;
            r_em_rd    <= 5'd0;
            r_em_mr    <= 1'b0;
            r_em_mw    <= 1'b0;
            r_em_m2r   <= 1'b0;
            r_em_rw    <= 1'b0;
        end else if (!stall) begin
            r_em_valid <= ex_valid & ~flush;
            r_em_alu   <= ALUResult;
            r_em_sdata <= readData2;
            r_em_tgt   <= PCPlusImmShifted;
            r_em_taken <= BranchTaken;
            r_em_rd    <= rd;
            r_em_mr    <= MemRead;
            r_em_mw    <= MemWrite;
            r_em_m2r   <= MemtoReg;
            r_em_rw    <= RegWrite;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wb_valid <= 1'b0;
            r_wb_rw    <= 1'b0;
            r_wb_rd    <= 5'd0;
            r_wb_data  <= 64'd0;
        end else if (!stall) begin
            r_wb_valid <= r_em_valid;
            r_wb_rw    <= r_em_valid & r_em_rw & (r_em_rd != 5'd0);
            r_wb_rd    <= r_em_rd;
            r_wb_data  <= r_em_m2r ? w_ld_data : r_em_alu;
        end
    end

endmodule

// File: tb/tb_ex_mem_wb_pipe.sv
// tb_ex_mem_wb_pipe: directed and randomized checks of ex_mem_wb_pipe
// against an instruction-level reference model of the back end.
module tb_ex_mem_wb_pipe;

    localparam int DEPTH = 256;
    localparam int IDX_W = 8;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        ex_valid;
    logic [63:0] ALUResult;
    logic [63:0] readData2;
    logic [63:0] PCPlusImmShifted;
    logic        BranchTaken;
    logic [4:0]  rd;
    logic        MemRead;
    logic        MemWrite;
    logic        MemtoReg;
    logic        RegWrite;
    logic        PCSrc;
    logic [63:0] BranchTarget;
    logic        mem_err;
    logic        wb_valid;
    logic        wb_RegWrite;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;

    ex_mem_wb_pipe #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clk(clk),
        .reset(reset),
        .stall(stall),
        .flush(flush),
        .ex_valid(ex_valid),
        .ALUResult(ALUResult),
        .readData2(readData2),
        .PCPlusImmShifted(PCPlusImmShifted),
        .BranchTaken(BranchTaken),
        .rd(rd),
        .MemRead(MemRead),
        .MemWrite(MemWrite),
        .MemtoReg(MemtoReg),
        .RegWrite(RegWrite),
        .PCSrc(PCSrc),
        .BranchTarget(BranchTarget),
        .mem_err(mem_err),
        .wb_valid(wb_valid),
        .wb_RegWrite(wb_RegWrite),
        .wb_rd(wb_rd),
        .wb_data(wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [63:0] alu;
        logic [63:0] sd;
        logic [63:0] tgt;
        logic        bt;
        logic [4:0]  rd;
        logic        mr;
        logic        mw;
        logic        m2r;
        logic        rw;
    } ins_t;

    typedef struct {
        logic        v;
        logic        rw;
        logic [4:0]  rd;
        logic [63:0] data;
    } wb_t;

    int n_chk = 0;
    int n_pass = 0;

    ins_t        m_em;
    wb_t         m_wb;
    logic [63:0] m_mem [DEPTH];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic is_bad(input logic [63:0] a);
        logic [63:0] lim;
        lim = 64'(DEPTH) * 64'd8;
        return (a % 64'd8 != 64'd0) || (a >= lim);
    endfunction

    function automatic int word_of(input logic [63:0] a);
        return int'(a / 64'd8);
    endfunction

    task automatic model_edge(input ins_t in, input logic r, input logic s,
                              input logic f);
        logic [63:0] ld;
        if (r) begin
            m_em = '{default: '0};
            m_wb = '{default: '0};
        end else if (!s) begin
            ld = 64'd0;
            if (!is_bad(m_em.alu)) ld = m_mem[word_of(m_em.alu)];
            if (m_em.v && m_em.mw && !is_bad(m_em.alu))
                m_mem[word_of(m_em.alu)] = m_em.sd;
            m_wb.v    = m_em.v;
            m_wb.rw   = m_em.v && m_em.rw && (m_em.rd != 5'd0);
            m_wb.rd   = m_em.rd;
            m_wb.data = m_em.m2r ? ld : m_em.alu;
            m_em      = in;
            m_em.v    = in.v && !f;
        end
    endtask

    task automatic cycle();
        ins_t in;
        logic r, s, f;
        in.v   = ex_valid;
        in.alu = ALUResult;
        in.sd  = readData2;
        in.tgt = PCPlusImmShifted;
        in.bt  = BranchTaken;
        in.rd  = rd;
        in.mr  = MemRead;
        in.mw  = MemWrite;
        in.m2r = MemtoReg;
        in.rw  = RegWrite;
        r = reset;
        s = stall;
        f = flush;
        @(posedge clk);
        model_edge(in, r, s, f);
        #1;
        chk("PCSrc", PCSrc, m_em.v & m_em.bt);
        chk("BranchTarget", BranchTarget, m_em.v ? m_em.tgt : 64'd0);
        chk("mem_err", mem_err,
            m_em.v & (m_em.mr | m_em.mw) & is_bad(m_em.alu));
        chk("wb_valid", wb_valid, m_wb.v);
        chk("wb_RegWrite", wb_RegWrite, m_wb.rw);
        if (m_wb.v) begin
            chk("wb_rd", wb_rd, m_wb.rd);
            chk("wb_data", wb_data, m_wb.data);
        end
    endtask

    task automatic drive(input logic v, input logic [63:0] alu,
                         input logic [63:0] sd, input logic [63:0] tgt,
                         input logic bt, input logic [4:0] d,
                         input logic mr, input logic mw,
                         input logic m2r, input logic rw);
        ex_valid         = v;
        ALUResult        = alu;
        readData2        = sd;
        PCPlusImmShifted = tgt;
        BranchTaken      = bt;
        rd               = d;
        MemRead          = mr;
        MemWrite         = mw;
        MemtoReg         = m2r;
        RegWrite         = rw;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic op_add(input logic [63:0] a, input logic [4:0] d);
        drive(1, a, 0, 0, 0, d, 0, 0, 0, 1);
    endtask

    task automatic op_sd(input logic [63:0] a, input logic [63:0] x);
        drive(1, a, x, 0, 0, 0, 0, 1, 0, 0);
    endtask

    task automatic op_ld(input logic [63:0] a, input logic [4:0] d);
        drive(1, a, 0, 0, 0, d, 1, 0, 1, 1);
    endtask

    function automatic logic [63:0] rnd_addr();
        logic [63:0] a;
        int k;
        a = 64'($urandom_range(DEPTH - 1)) * 64'd8;
        k = $urandom_range(9);
        if (k == 0) a = a + 64'($urandom_range(7, 1));
        if (k == 1) a = a | (64'd1 << $urandom_range(63, IDX_W + 3));
        return a;
    endfunction

    task automatic rnd_op();
        int k;
        logic [4:0] d;
        logic [63:0] x;
        k = $urandom_range(5);
        d = 5'($urandom_range(31));
        x = {$urandom, $urandom};
        if (k == 0) idle();
        else if (k == 1) op_add(x, d);
        else if (k == 2) op_sd(rnd_addr(), x);
        else if (k == 3) op_ld(rnd_addr(), d);
        else if (k == 4) drive(1, x, 0, {$urandom, $urandom}, 1, d, 0, 0, 0, 0);
        else drive(1, rnd_addr(), x, x, 0, d, 1, 0, 0, 1);
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        idle();
        m_em = '{default: '0};
        m_wb = '{default: '0};
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 64'd0;

        cycle();
        cycle();
        chk("rst_PCSrc", PCSrc, 0);
        chk("rst_BranchTarget", BranchTarget, 0);
        chk("rst_mem_err", mem_err, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_RegWrite", wb_RegWrite, 0);
        chk("rst_wb_rd", wb_rd, 0);
        chk("rst_wb_data", wb_data, 0);
        reset = 1'b0;

        for (int i = 0; i < DEPTH; i++) begin
            op_sd(64'(i) * 64'd8, {$urandom, $urandom});
            cycle();
        end

        op_add(64'h1234, 5);
        cycle();
        idle();
        cycle();
        chk("add_wb_valid", wb_valid, 1);
        chk("add_wb_RegWrite", wb_RegWrite, 1);
        chk("add_wb_rd", wb_rd, 5);
        chk("add_wb_data", wb_data, 64'h1234);

        op_sd(64'h40, 64'hDEADBEEFCAFEF00D);
        cycle();
        op_ld(64'h40, 7);
        cycle();
        idle();
        cycle();
        chk("sdld_wb_rd", wb_rd, 7);
        chk("sdld_wb_data", wb_data, 64'hDEADBEEFCAFEF00D);

        drive(1, 0, 0, 64'h200, 1, 0, 0, 0, 0, 0);
        cycle();
        chk("br_PCSrc", PCSrc, 1);
        chk("br_BranchTarget", BranchTarget, 64'h200);
        op_add(64'h77, 3);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("flush_PCSrc", PCSrc, 0);
        chk("flush_BranchTarget", BranchTarget, 0);
        idle();
        cycle();
        chk("flush_wb_valid", wb_valid, 0);
        chk("flush_wb_RegWrite", wb_RegWrite, 0);

        op_sd(64'h8, 64'h22);
        cycle();
        op_add(64'h99, 9);
        cycle();
        op_sd(64'h8, 64'h11);
        cycle();
        op_ld(64'h8, 10);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall_wb_valid", wb_valid, 1);
            chk("stall_wb_rd", wb_rd, 9);
            chk("stall_wb_data", wb_data, 64'h99);
            chk("stall_wb_RegWrite", wb_RegWrite, 1);
        end
        chk("stall_model_word1", m_mem[1], 64'h22);
        stall = 1'b0;
        cycle();
        idle();
        cycle();
        chk("stall_ld_rd", wb_rd, 10);
        chk("stall_ld_data", wb_data, 64'h11);

        op_ld(64'h43, 4);
        cycle();
        chk("mis_mem_err", mem_err, 1);
        idle();
        cycle();
        chk("mis_wb_data", wb_data, 0);
        chk("mis_wb_RegWrite", wb_RegWrite, 1);

        op_sd(64'h0, 64'hA5A5);
        cycle();
        op_sd(64'(DEPTH) * 64'd8, 64'hBAD);
        cycle();
        chk("oob_mem_err", mem_err, 1);
        op_ld(64'h0, 6);
        cycle();
        op_add(64'h43, 2);
        cycle();
        chk("add43_mem_err", mem_err, 0);
        chk("oob_ld_data", wb_data, 64'hA5A5);

        op_add(64'h55, 0);
        cycle();
        idle();
        cycle();
        chk("rd0_wb_valid", wb_valid, 1);
        chk("rd0_wb_RegWrite", wb_RegWrite, 0);

        op_add(64'h66, 8);
        cycle();
        op_ld(64'h40, 11);
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("rrst_PCSrc", PCSrc, 0);
        chk("rrst_BranchTarget", BranchTarget, 0);
        chk("rrst_mem_err", mem_err, 0);
        chk("rrst_wb_valid", wb_valid, 0);
        chk("rrst_wb_RegWrite", wb_RegWrite, 0);
        chk("rrst_wb_rd", wb_rd, 0);
        chk("rrst_wb_data", wb_data, 0);

        for (int i = 0; i < 400; i++) begin
            rnd_op();
            stall = ($urandom_range(5) == 0);
            flush = ($urandom_range(6) == 0);
            reset = ($urandom_range(60) == 0);
            cycle();
        end
        reset = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        idle();
        cycle();
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
